// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and Avalon-side signal bundle for the memory bus arbiter.
// The arbiter is the bus master; the slave view belongs to the environment.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // instruction fetch requester
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_rdata;
    logic              fetch_done;

    // load/store requester
    logic              data_req;
    logic              data_write;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [BE_W-1:0]   data_byteenable;
    logic [DATA_W-1:0] data_rdata;
    logic              data_done;

    // external memory bus
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [BE_W-1:0]   avm_byteenable;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    modport master (
        input  fetch_req, fetch_addr,
        input  data_req, data_write, data_addr, data_wdata, data_byteenable,
        input  avm_readdata, avm_waitrequest,
        output fetch_rdata, fetch_done, data_rdata, data_done,
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
    );

    modport slave (
        output fetch_req, fetch_addr,
        output data_req, data_write, data_addr, data_wdata, data_byteenable,
        output avm_readdata, avm_waitrequest,
        input  fetch_rdata, fetch_done, data_rdata, data_done,
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one Avalon-style memory port between instruction fetch and load/store.
// Data wins ties; a requester is never re-granted in the cycle its done is high.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.master bus,
    output logic              busy
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_t;

    state_t            state, state_nx;
    req_t              lat;
    logic              grant_fetch, grant_data, xfer_end;
    logic [DATA_W-1:0] fetch_rdata_q, data_rdata_q;
    logic              fetch_done_q, data_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Done registers double as the "just served" mask for the grant decision.
    always_comb begin
        state_nx    = state;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        xfer_end    = !bus.avm_waitrequest;
        case (state)
            IDLE: begin
                if (bus.data_req && !data_done_q) begin
                    grant_data = 1'b1;
                    state_nx   = DATA;
                end else if (bus.fetch_req && !fetch_done_q) begin
                    grant_fetch = 1'b1;
                    state_nx    = FETCH;
                end
            end
            FETCH, DATA: if (xfer_end) state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
    end

    // Bus outputs depend only on registered state, so they hold through stalls.
    always_comb begin
        bus.avm_address    = '0;
        bus.avm_read       = 1'b0;
        bus.avm_write      = 1'b0;
        bus.avm_writedata  = '0;
        bus.avm_byteenable = '0;
        case (state)
            FETCH: begin
                bus.avm_read       = 1'b1;
                bus.avm_address    = lat.addr & ~ADDR_W'(3);
                bus.avm_byteenable = {BE_W{1'b1}};
            end
            DATA: begin
                bus.avm_address    = lat.addr & ~ADDR_W'(3);
                bus.avm_byteenable = lat.be;
                if (lat.write) begin
                    bus.avm_write     = 1'b1;
                    bus.avm_writedata = lat.wdata;
                end else begin
                    bus.avm_read = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat           <= '0;
            fetch_rdata_q <= '0;
            data_rdata_q  <= '0;
            fetch_done_q  <= 1'b0;
            data_done_q   <= 1'b0;
        end else begin
            fetch_done_q <= 1'b0;
            data_done_q  <= 1'b0;
            if (grant_data) begin
                lat <= '{write: bus.data_write, addr: bus.data_addr,
                         wdata: bus.data_wdata, be: bus.data_byteenable};
            end else if (grant_fetch) begin
                lat <= '{write: 1'b0, addr: bus.fetch_addr,
                         wdata: {DATA_W{1'b0}}, be: {BE_W{1'b1}}};
            end
            if (state == FETCH && xfer_end) begin
                fetch_rdata_q <= bus.avm_readdata;
                fetch_done_q  <= 1'b1;
            end
            if (state == DATA && xfer_end) begin
                data_done_q <= 1'b1;
                if (!lat.write) data_rdata_q <= bus.avm_readdata;
            end
        end
    end

    assign bus.fetch_rdata = fetch_rdata_q;
    assign bus.fetch_done  = fetch_done_q;
    assign bus.data_rdata  = data_rdata_q;
    assign bus.data_done   = data_done_q;
    assign busy            = (state != IDLE);
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sequences and shares the CPU's single Avalon-style memory port between two requesters: instruction fetch (feeds the instruction register) and data load/store.
- Owns read/write strobes, address latching and waitrequest stalls, and returns read data with a one-cycle done pulse to the granted requester.
- Sits between the CPU control FSM/datapath and the external memory bus.

Parameters:
ADDR_W, 32, address width for the requester and bus address ports
DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low (0 = reset)
fetch_req  input  1  level; instruction fetch request, held until fetch_done
fetch_addr  input  ADDR_W  fetch address (PC)
fetch_rdata  output  DATA_W  fetched instruction word
fetch_done  output  1  one-cycle pulse: fetch_rdata valid
data_req  input  1  level; load/store request, held until data_done
data_write  input  1  1 = store, 0 = load; sampled at grant
data_addr  input  ADDR_W  load/store address
data_wdata  input  DATA_W  store data
data_byteenable  input  DATA_W/8  store/load byte lanes
data_rdata  output  DATA_W  load result
data_done  output  1  one-cycle pulse: data access complete
avm_address  output  ADDR_W  bus address, word-aligned
avm_read  output  1  bus read strobe
avm_write  output  1  bus write strobe
avm_writedata  output  DATA_W  bus write data
avm_byteenable  output  DATA_W/8  bus byte lanes
avm_readdata  input  DATA_W  bus read data
avm_waitrequest  input  1  bus stall
busy  output  1  1 when state != IDLE

Behaviour:
- States: IDLE, FETCH, DATA. Reset (async, reset=0): state IDLE; fetch_rdata, data_rdata, fetch_done, data_done = 0; all avm_* outputs 0; busy 0.
- Grant in IDLE on clock edge: data_req has priority over fetch_req; if both are high, go to DATA. Latch address, wdata, byteenable and write flag into internal registers at grant; requester inputs are ignored until done.
- A requester whose done is high in the current cycle is not eligible for grant in that cycle, so a held-over req is never double-served. The other requester may be granted.
- FETCH: avm_read=1, avm_write=0, avm_address={latched[ADDR_W-1:2],2'b00}, avm_byteenable=all ones. On an edge where avm_waitrequest=0: fetch_rdata<=avm_readdata, fetch_done<=1 for exactly one cycle, state to IDLE.
- DATA, load: avm_read=1, byteenable=latched. Completion captures data_rdata.
- DATA, store: avm_write=1, avm_writedata=latched. data_rdata is unchanged.
- DATA completion on waitrequest=0: data_done pulses one cycle, state to IDLE.
- Bus outputs are decoded from state and latched registers only. They are glitch-free and stable while waitrequest=1, for any number of stall cycles.
- Minimum latency: req high at edge N, strobe asserted in cycle N..N+1, done high in cycle after edge N+1 (2 cycles req to done). Each wait cycle adds 1.
- Back-to-back grants: done cycle is IDLE, so the next grant edge is the done edge. No bus strobe is asserted in the done cycle.
- Reset mid-transfer: strobes drop immediately (async); no done is issued for the aborted access.
- Outside FETCH/DATA all avm_* outputs are 0.

Test Plan:
- Reset then fetch_req=1, fetch_addr=0xBFC00000, waitrequest=0, readdata=0x8C220004 -> avm_read in 1 cycle at 0xBFC00000, byteenable 0xF; fetch_done one cycle later with fetch_rdata=0x8C220004; busy 1 for exactly 1 cycle.
- Fetch with waitrequest high 3 cycles -> avm_read/address stable 4 cycles; fetch_done only after waitrequest falls; total 5 cycles req to done.
- fetch_req and data_req (load, addr 0x00001006, byteenable 0x3) asserted same edge -> DATA first, avm_address=0x00001004; data_done; then FETCH; fetch_done; no overlap of strobes.
- Store data_wdata=0xDEADBEEF, byteenable 0xF, addr 0x2000 -> avm_write=1, writedata 0xDEADBEEF; data_done; data_rdata keeps prior value; avm_read never 1.
- Requester keeps req high during its done cycle -> no second grant in that cycle; new access only if req still high after the done cycle.
- reset=0 while in FETCH with waitrequest=1 -> avm_read=0 immediately, no fetch_done, state IDLE; after release a fresh fetch completes normally.
